// File: rtl/cache_pkg.sv
// cache_pkg: shared state encoding, memory size code and address-field widths for the cache.
package cache_pkg;
    typedef enum logic [1:0] {IDLE, FETCH, WRITE, RESP} cache_state_t;
    localparam logic [2:0] MEMCTRL_WORD = 3'b010;
    function automatic int index_width(input int sets);
        return $clog2(sets);
    endfunction
    function automatic int tag_width(input int address_width, input int sets);
        return address_width - 2 - $clog2(sets);
    endfunction
endpackage

// File: rtl/cache_store.sv
// cache_store: direct-mapped valid/tag/data arrays with combinational lookup and one synchronous write port.
module cache_store
    import cache_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int SETS = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ADDRESS_WIDTH-3:0] line,
    input  logic                     fill,
    input  logic                     update,
    input  logic                     invalidate,
    input  logic [DATA_WIDTH-1:0]    wdata,
    output logic                     hit,
    output logic [DATA_WIDTH-1:0]    rdata
);
    localparam int IW = index_width(SETS);
    localparam int TW = tag_width(ADDRESS_WIDTH, SETS);
    logic [SETS-1:0] valid;
    logic [TW-1:0] tags [SETS];
    logic [DATA_WIDTH-1:0] data [SETS];
    logic [IW-1:0] idx;
    logic [TW-1:0] tag;
    assign idx = line[IW-1:0];
    assign tag = line[ADDRESS_WIDTH-3:IW];
    assign hit = valid[idx] && tags[idx] == tag;
    assign rdata = data[idx];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) valid <= '0;
        else if (fill) valid[idx] <= 1'b1;
        else if (invalidate) valid[idx] <= 1'b0;
    end
    // Tag/data need no reset: the valid bits guard them.
    always_ff @(posedge clk) begin
        if (fill) tags[idx] <= tag;
        if (fill || update) data[idx] <= wdata;
    end
endmodule

// File: rtl/cache_controller.sv
// cache_controller: write-through, no-write-allocate direct-mapped cache FSM with hit/miss statistics.
module cache_controller
    import cache_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int SETS = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_we,
    input  logic [ADDRESS_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0]    req_wdata,
    input  logic [2:0]               req_memcontrol,
    output logic                     rsp_valid,
    output logic [DATA_WIDTH-1:0]    rsp_rdata,
    output logic                     mem_req,
    output logic                     mem_we,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]    mem_wdata,
    output logic [2:0]               mem_memcontrol,
    input  logic                     mem_ack,
    input  logic [DATA_WIDTH-1:0]    mem_rdata,
    output logic [15:0]              hit_count,
    output logic [15:0]              miss_count
);
    cache_state_t state, state_next;
    logic hit, fill, update, invalidate, word;
    logic [DATA_WIDTH-1:0] line_data;
    logic [ADDRESS_WIDTH-3:0] line;
    // mem_addr doubles as the latched request address once a request leaves IDLE.
    assign line = state == IDLE ? req_addr[ADDRESS_WIDTH-1:2] : mem_addr[ADDRESS_WIDTH-1:2];
    assign word = mem_memcontrol == MEMCTRL_WORD;

    cache_store #(.ADDRESS_WIDTH(ADDRESS_WIDTH), .DATA_WIDTH(DATA_WIDTH), .SETS(SETS)) u_store (
        .clk(clk),
        .rst(rst),
        .line(line),
        .fill(fill),
        .update(update),
        .invalidate(invalidate),
        .wdata(state == FETCH ? mem_rdata : mem_wdata),
        .hit(hit),
        .rdata(line_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else state <= state_next;
    end

    always_comb begin
        state_next = state;
        fill = 1'b0;
        update = 1'b0;
        invalidate = 1'b0;
        req_ready = state == IDLE;
        rsp_valid = state == RESP;
        mem_req = state == FETCH || state == WRITE;
        mem_we = state == WRITE;
        case (state)
            IDLE: if (req_valid) state_next = req_we ? WRITE : hit ? RESP : FETCH;
            FETCH: if (mem_ack) begin
                state_next = RESP;
                fill = 1'b1;
            end
            WRITE: if (mem_ack) begin
                state_next = RESP;
                update = hit && word;
                invalidate = hit && !word;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_addr <= '0;
            mem_wdata <= '0;
            mem_memcontrol <= '0;
            rsp_rdata <= '0;
            hit_count <= '0;
            miss_count <= '0;
        end else begin
            if (state == IDLE && req_valid) begin
                mem_addr <= req_we ? req_addr : {req_addr[ADDRESS_WIDTH-1:2], 2'b00};
                mem_wdata <= req_we ? req_wdata : '0;
                mem_memcontrol <= req_we ? req_memcontrol : MEMCTRL_WORD;
                rsp_rdata <= req_we ? '0 : line_data;
                if (!req_we && hit && hit_count != 16'hFFFF) hit_count <= hit_count + 16'd1;
                if (!req_we && !hit && miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
            end
            if (state == FETCH && mem_ack) rsp_rdata <= mem_rdata;
        end
    end
endmodule
